// File: rtl/buffer_fill_ctrl_if.sv
// rtl/buffer_fill_ctrl_if.sv - write-beat handshake into the circular input buffer
interface buffer_fill_ctrl_if #(
    parameter int PAR_WRITE  = 4,
    parameter int DATA_WIDTH = 16
);
    logic                            in_valid;
    logic                            in_ready;
    logic [PAR_WRITE*DATA_WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/buffer_fill_ctrl.sv
// rtl/buffer_fill_ctrl.sv - circular input buffer write controller, storage and read port
// Optional sticky underflow flag enabled by defining BUFFER_UNDERFLOW_FLAG_EN.
module buffer_fill_ctrl #(
    parameter int COLUMNS    = 32,
    parameter int PAR_WRITE  = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    buffer_fill_ctrl_if.slave            in_if,
    input  logic [$clog2(COLUMNS)-1:0]   write_ptr,
    output logic                         updateWP,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic [$clog2(COLUMNS):0]     count,
    output logic                         full,
    output logic                         empty,
    output logic                         underflow
);
    localparam int AW = $clog2(COLUMNS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FILL_LIMIT = CW'(COLUMNS - PAR_WRITE);
    localparam logic [CW-1:0] COLS_C     = CW'(COLUMNS);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(COLUMNS - 1);

    logic [DATA_WIDTH-1:0] mem_q [COLUMNS];
    logic [DATA_WIDTH-1:0] mem_d [COLUMNS];
    logic [AW-1:0]         read_ptr_q, read_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  accept, fire;
    logic [CW-1:0]         lane_sum  [PAR_WRITE];
    logic [CW-1:0]         lane_wrap [PAR_WRITE];
    logic [AW-1:0]         lane_addr [PAR_WRITE];

    // Readiness ignores a same-cycle read so it depends on registered count only.
    assign in_if.in_ready = (count_q <= FILL_LIMIT);
    assign accept         = in_if.in_valid & in_if.in_ready & ~rst;
    assign fire           = rd_en & ~empty & ~rst;
    assign updateWP       = accept;

    assign count    = count_q;
    assign full     = (count_q == COLS_C);
    assign empty    = (count_q == '0);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // One extra bit lets a lane that runs past the end fold back to the start.
    always_comb begin
        for (int i = 0; i < PAR_WRITE; i++) begin
            lane_sum[i]  = {1'b0, write_ptr} + CW'(i);
            lane_wrap[i] = (lane_sum[i] >= COLS_C) ? (lane_sum[i] - COLS_C) : lane_sum[i];
            lane_addr[i] = lane_wrap[i][AW-1:0];
        end
    end

    always_comb begin
        mem_d      = mem_q;
        read_ptr_d = read_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (accept) begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                mem_d[lane_addr[i]] = in_if.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (fire) begin
            rd_data_d  = mem_q[read_ptr_q];
            rd_valid_d = 1'b1;
            read_ptr_d = (read_ptr_q == LAST_ADDR) ? '0 : read_ptr_q + 1'b1;
        end
        count_d = count_q + (accept ? CW'(PAR_WRITE) : '0) - (fire ? CW'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_ptr_q <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            read_ptr_q <= read_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
        mem_q <= mem_d;
    end

`ifdef BUFFER_UNDERFLOW_FLAG_EN
    logic underflow_q, underflow_d;

    always_comb begin
        underflow_d = underflow_q | (rd_en & empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_buffer_fill_ctrl.sv
// tb/tb_buffer_fill_ctrl.sv - scoreboard bench for buffer_fill_ctrl at 32 and 30 entries
module tb_buffer_fill_ctrl;
    localparam int PW = 4;
    localparam int DW = 16;
`ifdef BUFFER_UNDERFLOW_FLAG_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    buffer_fill_ctrl_if #(.PAR_WRITE(PW), .DATA_WIDTH(DW)) wif_a ();
    buffer_fill_ctrl_if #(.PAR_WRITE(PW), .DATA_WIDTH(DW)) wif_b ();

    logic [4:0]    wp_a, wp_b;
    logic          upd_a, upd_b, rd_en_a, rd_en_b, rv_a, rv_b;
    logic [DW-1:0] rd_a, rd_b;
    logic [5:0]    cnt_a, cnt_b;
    logic          full_a, full_b, empty_a, empty_b, uf_a, uf_b;

    buffer_fill_ctrl #(.COLUMNS(32), .PAR_WRITE(PW), .DATA_WIDTH(DW)) dut_a (
        .clk(clk), .rst(rst), .in_if(wif_a), .write_ptr(wp_a), .updateWP(upd_a),
        .rd_en(rd_en_a), .rd_data(rd_a), .rd_valid(rv_a), .count(cnt_a),
        .full(full_a), .empty(empty_a), .underflow(uf_a));

    buffer_fill_ctrl #(.COLUMNS(30), .PAR_WRITE(PW), .DATA_WIDTH(DW)) dut_b (
        .clk(clk), .rst(rst), .in_if(wif_b), .write_ptr(wp_b), .updateWP(upd_b),
        .rd_en(rd_en_b), .rd_data(rd_b), .rd_valid(rv_b), .count(cnt_b),
        .full(full_b), .empty(empty_b), .underflow(uf_b));

    // Pointer update stages feeding each buffer.
    always @(posedge clk) begin
        if (rst) begin
            wp_a <= '0;
            wp_b <= '0;
        end else begin
            if (upd_a) wp_a <= 5'((int'(wp_a) + PW) % 32);
            if (upd_b) wp_b <= 5'((int'(wp_b) + PW) % 30);
        end
    end

    int            n_chk  = 0;
    int            n_fail = 0;
    int            m_cnt [2];
    bit            m_uf  [2];
    logic [DW-1:0] m_last[2];
    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];
    int            n_upd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int base, input int cols);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < PW; i++) r[i*DW +: DW] = DW'((base + i) % cols);
        return r;
    endfunction

    task automatic tick(input int s, input bit v, input logic [63:0] d, input bit r, input bit rs);
        int            cols;
        bit            acc, fire;
        logic [DW-1:0] exp_rd;
        cols = (s == 0) ? 32 : 30;
        rst  = rs;
        if (s == 0) begin
            wif_a.in_valid = v; wif_a.in_data = d; rd_en_a = r;
        end else begin
            wif_b.in_valid = v; wif_b.in_data = d; rd_en_b = r;
        end
        acc    = v && !rs && (cols - m_cnt[s] >= PW);
        fire   = r && !rs && (m_cnt[s] > 0);
        exp_rd = m_last[s];
        #1;
        chk("in_ready", (s == 0) ? wif_a.in_ready : wif_b.in_ready, 64'(cols - m_cnt[s] >= PW));
        chk("updateWP", (s == 0) ? upd_a : upd_b, 64'(acc));
        if (fire) begin
            if (s == 0) exp_rd = q_a.pop_front();
            else        exp_rd = q_b.pop_front();
        end
        if (acc) begin
            for (int i = 0; i < PW; i++) begin
                if (s == 0) q_a.push_back(d[i*DW +: DW]);
                else        q_b.push_back(d[i*DW +: DW]);
            end
        end
        if (r && !rs && m_cnt[s] == 0) m_uf[s] = 1'b1;
        m_cnt[s]  = m_cnt[s] + (acc ? PW : 0) - (fire ? 1 : 0);
        m_last[s] = exp_rd;
        if (rs) begin
            m_cnt  = '{0, 0};
            m_uf   = '{1'b0, 1'b0};
            m_last = '{16'h0, 16'h0};
            q_a.delete();
            q_b.delete();
        end
        @(posedge clk);
        #1;
        chk("rd_valid",  (s == 0) ? rv_a    : rv_b,    64'(fire));
        chk("rd_data",   (s == 0) ? rd_a    : rd_b,    64'(m_last[s]));
        chk("count",     (s == 0) ? cnt_a   : cnt_b,   64'(m_cnt[s]));
        chk("full",      (s == 0) ? full_a  : full_b,  64'(m_cnt[s] == cols));
        chk("empty",     (s == 0) ? empty_a : empty_b, 64'(m_cnt[s] == 0));
        chk("underflow", (s == 0) ? uf_a    : uf_b,    64'(UF_EN ? m_uf[s] : 1'b0));
    endtask

    initial begin
        m_cnt  = '{0, 0};
        m_uf   = '{1'b0, 1'b0};
        m_last = '{16'h0, 16'h0};
        rst = 1'b1;
        wif_a.in_valid = 1'b0; wif_a.in_data = '0; rd_en_a = 1'b0;
        wif_b.in_valid = 1'b0; wif_b.in_data = '0; rd_en_b = 1'b0;
        @(posedge clk);
        #1;
        tick(0, 1'b0, '0, 1'b0, 1'b1);
        tick(0, 1'b0, '0, 1'b0, 1'b1);

        // Fill from reset with lane value = address.
        n_upd = 0;
        for (int k = 0; k < 8; k++) begin
            tick(0, 1'b1, mk(int'(wp_a), 32), 1'b0, 1'b0);
            n_upd++;
        end
        chk("fill_pulses", 64'(n_upd), 64'(m_cnt[0] / PW));
        chk("wp_after_fill", wp_a, 0);
        tick(0, 1'b1, 64'hdead_beef_cafe_f00d, 1'b0, 1'b0);

        for (int k = 0; k < 32; k++) tick(0, 1'b0, '0, 1'b1, 1'b0);
        tick(0, 1'b0, '0, 1'b1, 1'b0);
        tick(0, 1'b0, '0, 1'b0, 1'b0);

        // Simultaneous accept and fire, then blocked write at count 29.
        for (int k = 0; k < 7; k++) tick(0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        tick(0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
        chk("count_after_both", cnt_a, 31);
        tick(0, 1'b0, '0, 1'b1, 1'b0);
        tick(0, 1'b0, '0, 1'b1, 1'b0);
        tick(0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
        chk("count_read_only", cnt_a, 28);

        // Reset during an accept at count 12.
        for (int k = 0; k < 16; k++) tick(0, 1'b0, '0, 1'b1, 1'b0);
        chk("count_before_rst", cnt_a, 12);
        tick(0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1);
        tick(0, 1'b0, '0, 1'b0, 1'b0);

        // Write then read back-to-back after reset.
        tick(0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick(0, 1'b0, '0, 1'b1, 1'b0);
        tick(0, 1'b0, '0, 1'b0, 1'b0);

        // 30-entry buffer: walk write pointer to 28 then straddle the wrap.
        for (int k = 0; k < 7; k++) tick(1, 1'b1, mk(int'(wp_b), 30), 1'b0, 1'b0);
        for (int k = 0; k < 28; k++) tick(1, 1'b0, '0, 1'b1, 1'b0);
        chk("wp_b_before_wrap", wp_b, 28);
        tick(1, 1'b1, mk(int'(wp_b), 30), 1'b0, 1'b0);
        chk("wp_b_after_wrap", wp_b, 2);
        for (int k = 0; k < 4; k++) tick(1, 1'b0, '0, 1'b1, 1'b0);
        tick(1, 1'b0, '0, 1'b0, 1'b0);
        chk("sb_a_drained", 64'(q_a.size()), 0);
        chk("sb_b_drained", 64'(q_b.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
